nrz_symbol_tx: RTL



---
 rtl/nrz_symbol_tx.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/nrz_symbol_tx.sv
// nrz_symbol_tx: NCO-paced NRZ symbol transmitter. Each frame is an
// alternating 1/0 preamble, a fixed sync word sent MSB first, then a PRBS7
// (x^7+x^6+1) payload. Symbols map to +/-AMP signed 8-bit samples on y_n.
// Optional build macro NRZ_TX_ISI_EN adds a 2-tap post-cursor channel
// emulation: y_n = sat8(level_now + (level_prev >>> ISI_SHIFT)).
module nrz_symbol_tx #(
   parameter int                    PHASE_BITS   = 32,
   parameter logic [PHASE_BITS-1:0] FCW_NOM      = 32'd85_899_345,
   parameter logic signed [7:0]     AMP          = 8'sd64,
   parameter int                    PREAMBLE_LEN = 32,
   parameter int                    PAYLOAD_LEN  = 255,
   parameter logic [7:0]            SYNC_WORD    = 8'hD3,
   parameter logic [6:0]            PRBS_SEED    = 7'h7F
`ifdef NRZ_TX_ISI_EN
   ,
   parameter int                    ISI_SHIFT    = 2
`endif
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               start,
   input  logic               cont,
   input  logic signed [15:0] fcw_trim,
   output logic signed [7:0]  y_n,
   output logic               sym_stb,
   output logic               sym_bit,
   output logic [1:0]         state,
   output logic               frame_done
);

   // The trim sum is formed wide enough for both the FCW and the 16-bit trim
   // plus a sign bit and a guard bit, so saturation is decided without wrap.
   localparam int SUM_W = ((PHASE_BITS > 16) ? PHASE_BITS : 16) + 2;
   localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
   localparam logic [15:0] PAY_LAST = 16'(PAYLOAD_LEN - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      SYNC     = 2'd2,
      PAYLOAD  = 2'd3
   } state_t;

   state_t                 cur;
   state_t                 nxt_state;
   logic [PHASE_BITS-1:0]  phase;
   logic signed [SUM_W-1:0] fcw_sum;
   logic [PHASE_BITS-1:0]  fcw_eff;
   logic [PHASE_BITS:0]    acc;
   logic                   tick;
   logic [15:0]            cnt;
   logic [15:0]            nxt_cnt;
   logic [6:0]             lfsr;
   logic [6:0]             nxt_lfsr;
   logic                   nxt_bit;
   logic                   nxt_emit;
   logic                   nxt_done;
   logic signed [7:0]      nxt_level;
   logic signed [7:0]      nxt_y;

   function automatic logic [6:0] prbs_step(input logic [6:0] v);
      return {v[5:0], v[6] ^ v[5]};
   endfunction

   // Effective FCW: nominal plus signed trim, clamped so the NCO always
   // moves forward by at least one and never by a full turn.
   always_comb begin
      fcw_sum = $signed({{(SUM_W-PHASE_BITS){1'b0}}, FCW_NOM})
              + $signed({{(SUM_W-16){fcw_trim[15]}}, fcw_trim});
      if (fcw_sum[SUM_W-1] || (fcw_sum == '0)) begin
         fcw_eff = {{(PHASE_BITS-1){1'b0}}, 1'b1};
      end else if (fcw_sum[SUM_W-2:PHASE_BITS] != '0) begin
         fcw_eff = '1;
      end else begin
         fcw_eff = fcw_sum[PHASE_BITS-1:0];
      end
   end

   assign acc   = {1'b0, phase} + {1'b0, fcw_eff};
   assign tick  = en & acc[PHASE_BITS];
   assign state = cur;

   // Phase accumulator; the carry out of each accumulation is the symbol tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= '0;
      end else if (en) begin
         phase <= acc[PHASE_BITS-1:0];
      end
   end

   // Next-symbol decision: cnt is the index of the symbol currently on y_n
   // within the current state, so the last symbol of a state is cnt==LEN-1.
   always_comb begin
      nxt_state = cur;
      nxt_cnt   = cnt + 16'd1;
      nxt_bit   = 1'b0;
      nxt_lfsr  = lfsr;
      nxt_emit  = 1'b0;
      nxt_done  = 1'b0;
      case (cur)
         IDLE: begin
            nxt_cnt = '0;
            if (start) begin
               nxt_state = PREAMBLE;
               nxt_bit   = 1'b1;
               nxt_emit  = 1'b1;
            end
         end
         PREAMBLE: begin
            nxt_emit = 1'b1;
            if (cnt == PRE_LAST) begin
               nxt_state = SYNC;
               nxt_cnt   = '0;
               nxt_bit   = SYNC_WORD[7];
            end else begin
               nxt_bit = ~nxt_cnt[0];
            end
         end
         SYNC: begin
            nxt_emit = 1'b1;
            if (cnt == 16'd7) begin
               nxt_state = PAYLOAD;
               nxt_cnt   = '0;
               nxt_bit   = PRBS_SEED[6];
               nxt_lfsr  = prbs_step(PRBS_SEED);
               nxt_done  = (PAYLOAD_LEN == 1);
            end else begin
               nxt_bit = SYNC_WORD[3'd6 - cnt[2:0]];
            end
         end
         PAYLOAD: begin
            if (cnt == PAY_LAST) begin
               nxt_cnt = '0;
               if (cont) begin
                  nxt_state = PREAMBLE;
                  nxt_bit   = 1'b1;
                  nxt_emit  = 1'b1;
               end else begin
                  nxt_state = IDLE;
               end
            end else begin
               nxt_bit  = lfsr[6];
               nxt_lfsr = prbs_step(lfsr);
               nxt_emit = 1'b1;
               nxt_done = (nxt_cnt == PAY_LAST);
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
         end
      endcase
   end

   assign nxt_level = nxt_bit ? AMP : -AMP;

`ifdef NRZ_TX_ISI_EN
   logic signed [7:0] level_prev;
   logic signed [7:0] post_cursor;
   logic signed [9:0] isi_sum;

   assign post_cursor = level_prev >>> ISI_SHIFT;

   // Channel emulation: add the attenuated previous level and clamp to 8 bits.
   always_comb begin
      isi_sum = {{2{nxt_level[7]}}, nxt_level} + {{2{post_cursor[7]}}, post_cursor};
      if (isi_sum > 10'sd127) begin
         nxt_y = 8'sd127;
      end else if (isi_sum < -10'sd128) begin
         nxt_y = -8'sd128;
      end else begin
         nxt_y = isi_sum[7:0];
      end
   end

   // Previous emitted level; zero whenever the transmitter is idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_prev <= '0;
      end else if (tick) begin
         level_prev <= nxt_emit ? nxt_level : 8'sd0;
      end
   end
`else
   assign nxt_y = nxt_level;
`endif

   // Frame FSM with registered outputs; everything advances only on a tick,
   // and the strobes are single-cycle pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur        <= IDLE;
         cnt        <= '0;
         lfsr       <= PRBS_SEED;
         y_n        <= '0;
         sym_bit    <= 1'b0;
         sym_stb    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         sym_stb    <= 1'b0;
         frame_done <= 1'b0;
         if (tick) begin
            cur        <= nxt_state;
            cnt        <= nxt_cnt;
            lfsr       <= nxt_lfsr;
            sym_bit    <= nxt_bit;
            sym_stb    <= nxt_emit;
            frame_done <= nxt_done;
            y_n        <= nxt_emit ? nxt_y : 8'sd0;
         end
      end
   end

endmodule
